decode_stage: RTL and testbench

//  IF/ID pipeline stage: accepts fetched instructions from fetch over a valid/ready

---
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// IF/ID stage: two-entry (main + skid) buffer between fetch and execute.
// Each instruction is decoded into its immediate format when it is accepted,
// so execute sees a stored ImmSrc/illegal alongside Instr and PC.
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic [2:0]      ImmSrc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam logic [2:0] IMM_R   = 3'd0;
  localparam logic [2:0] IMM_I   = 3'd1;
  localparam logic [2:0] IMM_S   = 3'd2;
  localparam logic [2:0] IMM_B   = 3'd3;
  localparam logic [2:0] IMM_U   = 3'd4;
  localparam logic [2:0] IMM_J   = 3'd5;
  localparam logic [2:0] IMM_SYS = 3'd6;
  localparam logic [2:0] IMM_BAD = 3'd7;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      imm;
    logic            ill;
  } entry_t;

  // What an empty slot presents on the outputs: a harmless addi x0,x0,0.
  localparam entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: '0, imm: IMM_I, ill: 1'b0};

  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   skid_valid, main_valid_d, skid_valid_d;
  logic   accept, issue;

  // Classify an incoming word by opcode (and funct3 where the format depends on it).
  function automatic entry_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    entry_t e;
    e.instr = ins;
    e.pc    = pc;
    e.imm   = IMM_I;
    e.ill   = 1'b0;
    case (ins[6:0])
      OPC_OP_IMM: e.imm = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? IMM_R : IMM_I;
      OPC_LOAD,
      OPC_JALR,
      OPC_FENCE:  e.imm = IMM_I;
      OPC_STORE:  e.imm = IMM_S;
      OPC_BRANCH: e.imm = IMM_B;
      OPC_LUI,
      OPC_AUIPC:  e.imm = IMM_U;
      OPC_JAL:    e.imm = IMM_J;
      OPC_OP:     e.imm = IMM_R;
      OPC_SYSTEM: e.imm = (ins[14:12] inside {3'b101, 3'b110, 3'b111}) ? IMM_SYS : IMM_I;
      default: begin
        e.imm = IMM_BAD;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  assign accept   = in_valid & in_ready;
  assign issue    = out_valid & out_ready;
  assign in_entry = decode(in_instr, in_pc);

  // Next contents of main/skid: refill main from skid first so order is kept.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = out_valid;
    skid_valid_d = skid_valid;
    if (flush) begin
      main_d       = EMPTY_ENTRY;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid || issue) begin
      if (skid_valid) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_d       = EMPTY_ENTRY;
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; in_ready looks ahead at skid occupancy so it never depends on out_ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q     <= EMPTY_ENTRY;
      skid_q     <= EMPTY_ENTRY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      out_valid  <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= ~skid_valid_d;
    end
  end

  assign Instr   = main_q.instr;
  assign PC      = main_q.pc;
  assign ImmSrc  = main_q.imm;
  assign illegal = main_q.ill;
  assign rs1     = main_q.instr[19:15];
  assign rs2     = main_q.instr[24:20];
  assign rd      = main_q.instr[11:7];

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage: accepted instructions are queued
// by the driver, and a negedge monitor checks the head of the queue against the
// DUT output, popping on every issue.
module tb_decode_stage;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [2:0]  ImmSrc;
  logic [4:0]  rs1, rs2, rd;
  logic        illegal;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } txn_t;

  txn_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   mon_en = 0;
  int   fmt_of[bit [6:0]];

  decode_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .Instr(Instr), .PC(PC), .ImmSrc(ImmSrc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Immediate format by opcode, with the two funct3-dependent exceptions.
  function automatic int ref_fmt(input logic [31:0] ins);
    bit [6:0] op;
    bit [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    if (!fmt_of.exists(op)) return 7;
    if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) return 0;
    if (op == 7'b1110011 && f3 >= 3'd5) return 6;
    return fmt_of[op];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs after the edge, then record an accept once the monitor has run.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic r, input logic f);
    txn_t t;
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = r;
    flush     = f;
    @(negedge CLK);
    #1;
    if (v && in_ready && !f && !RST) begin
      t.instr = ins;
      t.pc    = pc;
      q.push_back(t);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_budget actual=%0d entries left required=0", q.size());
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_Instr"},     Instr,          32'h0000_0013);
    chk({tag, "_PC"},        PC,             32'd0);
    chk({tag, "_ImmSrc"},    32'(ImmSrc),    32'd1);
    chk({tag, "_illegal"},   32'(illegal),   32'd0);
  endtask

  // Monitor: stage occupancy equals queue length; head must be on the outputs.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
      if (q.size() != 0) begin
        chk("Instr",   Instr,          q[0].instr);
        chk("PC",      PC,             q[0].pc);
        chk("ImmSrc",  32'(ImmSrc),    32'(ref_fmt(q[0].instr)));
        chk("illegal", 32'(illegal),   32'(ref_fmt(q[0].instr) == 7));
        chk("rs1",     32'(rs1),       32'(q[0].instr[19:15]));
        chk("rs2",     32'(rs2),       32'(q[0].instr[24:20]));
        chk("rd",      32'(rd),        32'(q[0].instr[11:7]));
      end else if (!out_valid) begin
        chk("empty_Instr", Instr, 32'h0000_0013);
      end
      if (!RST && out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (RST || flush) q.delete();
    end
  end

  logic [31:0] legal_ops [11];

  initial begin
    fmt_of[7'b0010011] = 1;
    fmt_of[7'b0000011] = 1;
    fmt_of[7'b1100111] = 1;
    fmt_of[7'b0100011] = 2;
    fmt_of[7'b1100011] = 3;
    fmt_of[7'b0110111] = 4;
    fmt_of[7'b0010111] = 4;
    fmt_of[7'b1101111] = 5;
    fmt_of[7'b0110011] = 0;
    fmt_of[7'b0001111] = 1;
    fmt_of[7'b1110011] = 1;
    legal_ops = '{32'h13, 32'h03, 32'h67, 32'h23, 32'h63, 32'h37,
                  32'h17, 32'h6F, 32'h33, 32'h0F, 32'h73};

    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0;

    // Reset held two cycles
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_values("reset");
    #1 mon_en = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;

    // Back-to-back stream: addi, sw, beq, lui, jal
    drive(1'b1, 32'h0050_0093, 32'h00, 1'b1, 1'b0);
    drive(1'b1, 32'h0020_a023, 32'h04, 1'b1, 1'b0);
    drive(1'b1, 32'h0020_8463, 32'h08, 1'b1, 1'b0);
    drive(1'b1, 32'h1234_52b7, 32'h0C, 1'b1, 1'b0);
    drive(1'b1, 32'h0100_00ef, 32'h10, 1'b1, 1'b0);
    drain();

    // Back-pressure: three offered, two fit
    drive(1'b1, 32'h0000_a103, 32'h100, 1'b0, 1'b0);
    drive(1'b1, 32'h0031_01b3, 32'h104, 1'b0, 1'b0);
    drive(1'b1, 32'h0041_8213, 32'h108, 1'b0, 1'b0);
    drive(1'b1, 32'h0041_8213, 32'h108, 1'b0, 1'b0);
    chk("stall_depth", 32'(q.size()), 32'd2);
    drain();

    // Flush with both entries full, an issue and a new input in the same cycle
    drive(1'b1, 32'h0000_0297, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0317, 32'h204, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0397, 32'h208, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    chk("post_flush_in_ready",  32'(in_ready),  32'd1);
    drain();

    // Decode corners: slli, csrrwi, csrrw, illegal opcode
    drive(1'b1, 32'h0020_9093, 32'h300, 1'b1, 1'b0);
    drive(1'b1, 32'h3051_5073, 32'h304, 1'b1, 1'b0);
    drive(1'b1, 32'h3051_1073, 32'h308, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_007F, 32'h30C, 1'b1, 1'b0);
    drain();

    // Reset while the skid entry is occupied
    drive(1'b1, 32'h0000_0413, 32'h400, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0493, 32'h404, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0513, 32'h408, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_reset_values("midrst");
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = legal_ops[$urandom_range(0, 10)][6:0];
      drive($urandom_range(0, 3) != 0, ins, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
